// File: rtl/parity_frame_rx_if.sv
// parity_frame_rx_if: serial line in, deframed result and status out.
// slave is the receiver side, master is the line driver / result consumer.
interface parity_frame_rx_if #(
   parameter int DATA_W = 3,
   parameter int CNT_W  = 8
);
   logic              bit_en;
   logic              rx;
   logic [DATA_W-1:0] data_out;
   logic              valid;
   logic              parity_err;
   logic              frame_err;
   logic [CNT_W-1:0]  err_count;
   logic              busy;

   modport slave (
      input  bit_en,
      input  rx,
      output data_out,
      output valid,
      output parity_err,
      output frame_err,
      output err_count,
      output busy
   );

   modport master (
      output bit_en,
      output rx,
      input  data_out,
      input  valid,
      input  parity_err,
      input  frame_err,
      input  err_count,
      input  busy
   );
endinterface

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: odd-parity frame receiver (start, LSB-first data,
// parity, stop) sampled on bit_en, with a saturating bad-frame counter.
module parity_frame_rx #(
   parameter int DATA_W = 3,
   parameter int CNT_W  = 8
) (
   input logic              clk,
   input logic              rst_n,
   parity_frame_rx_if.slave bus
);
   localparam int BW = (DATA_W < 2) ? 1 : $clog2(DATA_W);
   localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] payload_q;
   logic [DATA_W-1:0] payload_d;
   logic [DATA_W-1:0] data_q;
   logic [BW-1:0]     cnt_q;
   logic [CNT_W-1:0]  err_q;
   logic [CNT_W-1:0]  err_d;
   logic              par_q;
   logic              valid_q;
   logic              perr_q;
   logic              ferr_q;
   logic              busy_q;
   logic              par_ok;
   logic              bad;
   logic [DATA_W:0]   shift;

   // New bit enters at the MSB so the first data bit lands at bit 0.
   assign shift     = {bus.rx, payload_q};
   assign payload_d = shift[DATA_W:1];
   assign par_ok    = (par_q == ~^payload_q);
   assign bad       = !par_ok || !bus.rx;
   assign err_d     = (err_q == '1) ? err_q : err_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         payload_q <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         err_q     <= '0;
         par_q     <= 1'b0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         if (bus.bit_en) begin
            unique case (state_q)
               IDLE: begin
                  if (!bus.rx) begin
                     state_q <= DATA;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               DATA: begin
                  payload_q <= payload_d;
                  cnt_q     <= cnt_q + BW'(1);
                  if (cnt_q == LAST) begin
                     state_q <= PARITY;
                  end
               end
               PARITY: begin
                  par_q   <= bus.rx;
                  state_q <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  valid_q <= bus.rx && par_ok;
                  perr_q  <= !par_ok;
                  ferr_q  <= !bus.rx;
                  if (bus.rx && par_ok) begin
                     data_q <= payload_q;
                  end
                  if (bad) begin
                     err_q <= err_d;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.data_out   = data_q;
   assign bus.valid      = valid_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;
   assign bus.err_count  = err_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: directed vector table, corner sequences and
// random frames checked against a frame-level parity model.
module tb_parity_frame_rx;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   parity_frame_rx_if #(.DATA_W(3), .CNT_W(8)) bus ();

   parity_frame_rx #(.DATA_W(3), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int nv = 0;
   int np = 0;
   int nf = 0;
   int busy_bad = 0;
   logic [2:0] m_data = '0;
   int m_cnt = 0;

   typedef struct {
      logic [2:0] d;
      logic       p;
      logic       s;
      int         gap;
      logic [2:0] e_data;
      logic       e_v;
      logic       e_pe;
      logic       e_fe;
      int         e_cnt;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.valid) nv++;
      if (bus.parity_err) np++;
      if (bus.frame_err) nf++;
   endtask

   task automatic strobe(input logic b, input int gap, input bit in_frame);
      bus.bit_en = 1'b1;
      bus.rx = b;
      tick();
      if (in_frame && !bus.busy) busy_bad++;
      for (int i = 0; i < gap; i++) begin
         bus.bit_en = 1'b0;
         bus.rx = 1'b0;
         tick();
         if (in_frame && !bus.busy) busy_bad++;
      end
   endtask

   task automatic model(input logic [2:0] d, input logic p, input logic s,
                        output logic v, output logic pe, output logic fe);
      pe = ((($countones(d) + int'(p)) % 2) == 0);
      fe = !s;
      v = !pe && !fe;
      if (v) m_data = d;
      if ((pe || fe) && m_cnt < 255) m_cnt++;
   endtask

   task automatic run_frame(input string nm, input logic [2:0] d,
                            input logic p, input logic s, input int gap,
                            input logic e_v, input logic e_pe,
                            input logic e_fe, input logic [2:0] e_data,
                            input int e_cnt);
      int v0, p0, f0;
      v0 = nv;
      p0 = np;
      f0 = nf;
      busy_bad = 0;
      strobe(1'b0, gap, 1'b1);
      for (int i = 0; i < 3; i++) strobe(d[i], gap, 1'b1);
      strobe(p, gap, 1'b1);
      strobe(s, 0, 1'b0);
      chk({nm, ".valid"}, int'(bus.valid), int'(e_v));
      chk({nm, ".parity_err"}, int'(bus.parity_err), int'(e_pe));
      chk({nm, ".frame_err"}, int'(bus.frame_err), int'(e_fe));
      chk({nm, ".data_out"}, int'(bus.data_out), int'(e_data));
      chk({nm, ".err_count"}, int'(bus.err_count), e_cnt);
      chk({nm, ".busy_end"}, int'(bus.busy), 0);
      chk({nm, ".busy_frame"}, busy_bad, 0);
      chk({nm, ".n_valid"}, nv - v0, int'(e_v));
      chk({nm, ".n_perr"}, np - p0, int'(e_pe));
      chk({nm, ".n_ferr"}, nf - f0, int'(e_fe));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".data_out"}, int'(bus.data_out), 0);
      chk({nm, ".err_count"}, int'(bus.err_count), 0);
      chk({nm, ".valid"}, int'(bus.valid), 0);
      chk({nm, ".parity_err"}, int'(bus.parity_err), 0);
      chk({nm, ".frame_err"}, int'(bus.frame_err), 0);
      chk({nm, ".busy"}, int'(bus.busy), 0);
   endtask

   initial begin
      logic v, pe, fe, d0, p, s;
      logic [2:0] d;
      int gap;

      vecs[0] = '{3'b101, 1'b1, 1'b1, 0, 3'b101, 1'b1, 1'b0, 1'b0, 0};
      vecs[1] = '{3'b011, 1'b0, 1'b1, 0, 3'b101, 1'b0, 1'b1, 1'b0, 1};
      vecs[2] = '{3'b000, 1'b1, 1'b0, 0, 3'b101, 1'b0, 1'b0, 1'b1, 2};
      vecs[3] = '{3'b101, 1'b1, 1'b1, 2, 3'b101, 1'b1, 1'b0, 1'b0, 2};
      vecs[4] = '{3'b000, 1'b0, 1'b0, 0, 3'b101, 1'b0, 1'b1, 1'b1, 3};
      vecs[5] = '{3'b110, 1'b1, 1'b1, 1, 3'b110, 1'b1, 1'b0, 1'b0, 3};

      bus.bit_en = 1'b0;
      bus.rx = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      chk_zero("reset");
      rst_n = 1'b1;
      bus.bit_en = 1'b1;
      tick();
      chk("idle_busy", int'(bus.busy), 0);

      for (int i = 0; i < 6; i++) begin
         model(vecs[i].d, vecs[i].p, vecs[i].s, v, pe, fe);
         run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].p,
                   vecs[i].s, vecs[i].gap, vecs[i].e_v, vecs[i].e_pe,
                   vecs[i].e_fe, vecs[i].e_data, vecs[i].e_cnt);
         strobe(1'b1, 0, 1'b0);
         chk($sformatf("vec%0d.drop", i),
             int'({bus.valid, bus.parity_err, bus.frame_err}), 0);
      end

      strobe(1'b0, 0, 1'b1);
      strobe(1'b1, 0, 1'b1);
      strobe(1'b0, 0, 1'b1);
      rst_n = 1'b0;
      bus.bit_en = 1'b1;
      bus.rx = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_zero("midrst");
      m_data = '0;
      m_cnt = 0;
      strobe(1'b1, 0, 1'b0);
      chk("midrst.idle", int'(bus.busy), 0);
      run_frame("midrst_good", 3'b110, 1'b1, 1'b1, 0,
                1'b1, 1'b0, 1'b0, 3'b110, 0);

      for (int i = 0; i < 150; i++) begin
         d = 3'($urandom_range(0, 7));
         p = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 3) != 0);
         gap = $urandom_range(0, 2);
         for (int k = $urandom_range(0, 2); k > 0; k--) begin
            strobe(1'b1, 0, 1'b0);
         end
         model(d, p, s, v, pe, fe);
         run_frame($sformatf("rnd%0d", i), d, p, s, gap,
                   v, pe, fe, m_data, m_cnt);
      end

      d0 = 1'b0;
      for (int i = 0; i < 260; i++) begin
         model(3'b011, d0, 1'b1, v, pe, fe);
         run_frame($sformatf("sat%0d", i), 3'b011, d0, 1'b1, 0,
                   v, pe, fe, m_data, m_cnt);
      end
      chk("sat.final", int'(bus.err_count), 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial receiver that deframes a start/data/parity/stop bit stream and checks odd parity. The parity rule is parity = ~(d2 ^ d1 ^ d0) for the default 3-bit payload, so the total count of ones across data and parity is odd. The block sits downstream of the 3-input parity generator and consumes the frames it produces. It delivers the recovered data word, a one-cycle valid strobe, per-frame error flags, and a saturating error counter.

## Interface
Parameters:
- DATA_W, default 3: payload bits per frame (minimum 1).
- CNT_W, default 8: width of the error counter.

Ports:
- clk, input, 1: rising-edge clock; the only clock.
- rst_n, input, 1: synchronous, active-low reset; sampled on the clk rising edge.
- bit_en, input, 1: bit strobe; rx is sampled only on edges where bit_en = 1.
- rx, input, 1: serial line; idles at 1.
- data_out, output, DATA_W: last correctly received payload.
- valid, output, 1: one-cycle pulse when data_out is updated.
- parity_err, output, 1: one-cycle pulse when the frame's parity check fails.
- frame_err, output, 1: one-cycle pulse when the stop bit is sampled as 0.
- err_count, output, CNT_W: count of bad frames; saturates at all-ones.
- busy, output, 1: 1 in any state other than IDLE.

## Operation
- Frame format on the line, in order: start (0), DATA_W data bits (LSB first), parity bit, stop (1).
- FSM states are IDLE, DATA, PARITY and STOP. All transitions occur only on edges with bit_en = 1. When bit_en = 0, the state, shift register and bit counter hold.
- IDLE:
  - rx = 0 → go to DATA; clear the bit counter.
  - rx = 1 → stay in IDLE.
- DATA: shift rx into the payload register at the MSB end, shifting right, so the first data bit received ends up at bit 0. Increment the counter. After DATA_W bits, go to PARITY.
- PARITY: capture rx as p; go to STOP.
- STOP: evaluate the frame and return to IDLE. The parity check passes when p == ~^payload.
  - rx = 1 and parity OK → data_out <= payload; valid pulses.
  - rx = 1 and parity bad → parity_err pulses; data_out unchanged.
  - rx = 0 and parity OK → frame_err pulses; data_out unchanged.
  - rx = 0 and parity bad → parity_err and frame_err both pulse; data_out unchanged.
- A frame with any error increments err_count by exactly 1, including the case where both flags pulse. At all-ones, err_count holds.
- No break or false-start filtering. Any rx = 0 sampled in IDLE starts a frame.
- busy = 1 in DATA, PARITY and STOP.

## Timing
- Reset: when rst_n = 0 on an edge, the following are forced:
  - state → IDLE
  - data_out, err_count, payload, bit counter → 0
  - valid, parity_err, frame_err, busy → 0
- Reset takes priority over everything, including mid-frame. A partial frame is discarded and produces no flags.
- All outputs are registered.
- valid, parity_err and frame_err go high in the cycle after the edge that samples the stop bit. They stay high for exactly one clk cycle, even if bit_en stays high.
- err_count and data_out update on that same edge.
- Frame duration: a frame needs DATA_W + 3 bit_en strobes. With bit_en tied to 1, a 3-bit frame occupies 6 clocks from the start-bit edge to the result.
- Back-to-back frames: the strobe after the stop bit is sampled in IDLE. If rx = 0 there, the next frame starts with no gap.
- Simultaneous events: a result pulse and a new start bit on consecutive strobes are both honoured; no strobe is lost.

## Test plan
- Good frame, bit_en = 1, rx sequence 0,1,0,1,1,1:
  - data_out = 3'b101, valid high one cycle.
  - parity_err = frame_err = 0, err_count = 0.
- Parity error, rx sequence 0,1,1,0,0,1 (payload 3'b011, p = 0; expected p = 1):
  - parity_err pulses once, no valid.
  - data_out keeps its previous value (3'b101), err_count = 1.
- Frame error, rx sequence 0,0,0,0,1,0 (payload 000, p = 1 correct, stop bit 0):
  - frame_err pulses, parity_err = 0, no valid, err_count increments by 1.
- bit_en gaps: the good-frame sequence is applied with bit_en = 1 only every 3rd clock and rx = 0 on the non-strobe clocks.
  - Result matches the good-frame case: data_out = 3'b101, one valid pulse.
  - busy stays high throughout the frame.
- Reset mid-frame: assert rst_n = 0 for 1 clock after the 2nd data bit.
  - All outputs are 0 and state is IDLE.
  - A following good frame 0,0,1,1,1,1 gives data_out = 3'b110 with one valid pulse.
- Saturation: 260 consecutive parity-error frames, back-to-back.
  - err_count reaches 255 and stays at 255.
  - parity_err pulses on every frame.
